// File: rtl/ram_arb_pkg.sv
// Shared types and default geometry for the RAM access arbiter.
// Optional feature macro: RAM_ARB_RR_EN (round-robin arbitration).
package ram_arb_pkg;

  // Default geometry of the 16x4 data RAM this arbiter fronts.
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 4;

  // Access sequencer states: one RAM access spans IDLE->CMD->CAPT->ACK.
  typedef enum logic [1:0] {
    IDLE,
    CMD,
    CAPT,
    ACK
  } state_t;

  // Fields of one request, captured at grant time.
  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } req_t;

endpackage

// File: rtl/ram_arb_if.sv
// Requester-side bus of the RAM arbiter: two request/ack ports.
// Port 0 is the CPU datapath, port 1 the program loader/debug path.
// Optional feature macro: RAM_ARB_RR_EN (no effect on this interface).
interface ram_arb_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);

  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;

  // Requesters drive the request fields and receive ack/rdata.
  modport master (
    output req0, we0, addr0, wdata0,
    input  ack0, rdata0,
    output req1, we1, addr1, wdata1,
    input  ack1, rdata1
  );

  // The arbiter receives the request fields and drives ack/rdata.
  modport slave (
    input  req0, we0, addr0, wdata0,
    output ack0, rdata0,
    input  req1, we1, addr1, wdata1,
    output ack1, rdata1
  );

endinterface

// File: rtl/ram_arb_pick.sv
// Combinational winner select between the two request ports.
// Optional feature macro: RAM_ARB_RR_EN -- when defined, the port not
// granted last wins a conflict; otherwise port 0 always wins.
module ram_arb_pick (
  input  logic req0,
  input  logic req1,
`ifdef RAM_ARB_RR_EN
  input  logic last_grant,
`endif
  output logic grant_vld,
  output logic grant_idx
);

  // Pick a winner whenever at least one port is requesting.
  always_comb begin
    grant_vld = req0 | req1;
`ifdef RAM_ARB_RR_EN
    if (last_grant) begin
      grant_idx = req0 ? 1'b0 : 1'b1;
    end else begin
      grant_idx = req1 ? 1'b1 : 1'b0;
    end
`else
    grant_idx = req0 ? 1'b0 : 1'b1;
`endif
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port access controller for the 16x4 data RAM.
// Serialises requests into single RAM commands (one access per 4 cycles),
// captures the RAM's registered read data and returns it with a 1-cycle ack.
// Optional feature macro: RAM_ARB_RR_EN (round-robin arbitration; default
// build uses fixed priority with port 0 winning).
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  ram_arb_if.slave          bus,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dataIN,
  input  logic [DATA_W-1:0] ram_dataOut,
  output logic              busy
);

  state_t            state_q, state_d;
  logic              port_q, port_d;     // index of the granted port
  logic              we_q, we_d;         // granted access is a write
  logic              wen_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] din_d;
  logic              ack0_d, ack1_d;
  logic [DATA_W-1:0] rdata0_d, rdata1_d;
  logic              busy_d;
  logic              grant_vld;
  logic              grant_idx;
  req_t              sel_req;

`ifdef RAM_ARB_RR_EN
  logic              last_q, last_d;     // port granted most recently
`endif

  ram_arb_pick u_pick (
    .req0       (bus.req0),
    .req1       (bus.req1),
`ifdef RAM_ARB_RR_EN
    .last_grant (last_q),
`endif
    .grant_vld  (grant_vld),
    .grant_idx  (grant_idx)
  );

  // Route the winning port's request fields to a single record.
  always_comb begin
    if (grant_idx) begin
      sel_req.we    = bus.we1;
      sel_req.addr  = ADDR_W_DEF'(bus.addr1);
      sel_req.wdata = DATA_W_DEF'(bus.wdata1);
    end else begin
      sel_req.we    = bus.we0;
      sel_req.addr  = ADDR_W_DEF'(bus.addr0);
      sel_req.wdata = DATA_W_DEF'(bus.wdata0);
    end
  end

  // Next-state and next-output logic of the access sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    port_d   = port_q;
    we_d     = we_q;
    wen_d    = 1'b0;
    addr_d   = ram_addr;
    din_d    = ram_dataIN;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = bus.rdata0;
    rdata1_d = bus.rdata1;
`ifdef RAM_ARB_RR_EN
    last_d   = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          state_d = CMD;
          port_d  = grant_idx;
          we_d    = sel_req.we;
          wen_d   = sel_req.we;
          addr_d  = ADDR_W'(sel_req.addr);
          din_d   = DATA_W'(sel_req.wdata);
`ifdef RAM_ARB_RR_EN
          last_d  = grant_idx;
`endif
        end
      end
      CMD: begin
        // RAM executes the command at the edge ending this state.
        state_d = CAPT;
      end
      CAPT: begin
        // Registered RAM output now holds the read result.
        if (!we_q) begin
          if (port_q) rdata1_d = ram_dataOut;
          else        rdata0_d = ram_dataOut;
        end
        if (port_q) ack1_d = 1'b1;
        else        ack0_d = 1'b1;
        state_d = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; synchronous reset aborts any access.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples its pre-edge inputs regardless of statement order.
    if (rst) begin
      state_q      <= IDLE;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      ram_write_en <= 1'b0;
      ram_addr     <= '0;
      ram_dataIN   <= '0;
      bus.ack0     <= 1'b0;
      bus.ack1     <= 1'b0;
      bus.rdata0   <= '0;
      bus.rdata1   <= '0;
      busy         <= 1'b0;
`ifdef RAM_ARB_RR_EN
      last_q       <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      we_q         <= we_d;
      ram_write_en <= wen_d;
      ram_addr     <= addr_d;
      ram_dataIN   <= din_d;
      bus.ack0     <= ack0_d;
      bus.ack1     <= ack1_d;
      bus.rdata0   <= rdata0_d;
      bus.rdata1   <= rdata1_d;
      busy         <= busy_d;
`ifdef RAM_ARB_RR_EN
      last_q       <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural 16x4 RAM.
// Expectations follow RAM_ARB_RR_EN when the bench is built with it.
module tb_ram_arbiter;

  localparam int AW = 4;
  localparam int DW = 4;
`ifdef RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    bit            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_r0;   // rdata0 expected at ack
    logic [DW-1:0] exp_r1;   // rdata1 expected at ack
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ram_write_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dataIN;
  logic [DW-1:0] ram_dataOut;
  logic          busy;

  int n_pass  = 0;
  int n_total = 0;
  int wen_cnt = 0;
  int ev_port [16];
  int ev_cyc  [16];

  vec_t vecs [10];

  ram_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .ram_write_en (ram_write_en),
    .ram_addr     (ram_addr),
    .ram_dataIN   (ram_dataIN),
    .ram_dataOut  (ram_dataOut),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: write on write_en, registered read with 1-cycle latency.
  logic [DW-1:0] mem [16];
  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset, matching the real part; a reset of
    // the arbiter never clears stored data.
    if (ram_write_en) mem[ram_addr] <= ram_dataIN;
    ram_dataOut <= mem[ram_addr];
  end

  // Count every cycle the RAM sees a write command.
  always_ff @(posedge clk) begin
    if (ram_write_en) wen_cnt <= wen_cnt + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  function automatic int ack_of(input bit port);
    return port ? int'(bus.ack1) : int'(bus.ack0);
  endfunction

  task automatic drive_req(input bit port, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata);
    if (port) begin
      bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata; bus.req1 = 1'b1;
    end else begin
      bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata; bus.req0 = 1'b1;
    end
  endtask

  // One isolated transaction from IDLE; checks the full 4-cycle timeline.
  task automatic do_txn(input vec_t v, input string tag);
    drive_req(v.port, v.we, v.addr, v.wdata);
    tick();  // CMD
    check({tag, " cmd busy"}, int'(busy), 1);
    check({tag, " cmd write_en"}, int'(ram_write_en), int'(v.we));
    check({tag, " cmd addr"}, int'(ram_addr), int'(v.addr));
    if (v.we) check({tag, " cmd dataIN"}, int'(ram_dataIN), int'(v.wdata));
    tick();  // CAPT
    check({tag, " capt write_en"}, int'(ram_write_en), 0);
    check({tag, " capt no ack"}, ack_of(v.port), 0);
    tick();  // ACK
    check({tag, " ack"}, ack_of(v.port), 1);
    check({tag, " other ack"}, ack_of(!v.port), 0);
    check({tag, " rdata0"}, int'(bus.rdata0), int'(v.exp_r0));
    check({tag, " rdata1"}, int'(bus.rdata1), int'(v.exp_r1));
    if (v.port) bus.req1 = 1'b0; else bus.req0 = 1'b0;
    tick();  // IDLE
    check({tag, " ack drop"}, ack_of(v.port), 0);
    check({tag, " idle busy"}, int'(busy), 0);
  endtask

  // Both ports request together; records ack events until n_acks or budget.
  task automatic run_both(input bit hold, input int n_acks, input int budget,
                          output int n_got);
    int cyc;
    cyc   = 0;
    n_got = 0;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    while (n_got < n_acks && cyc < budget) begin
      tick();
      cyc++;
      if (bus.ack0) begin
        ev_port[n_got] = 0; ev_cyc[n_got] = cyc; n_got++;
        if (!hold) bus.req0 = 1'b0;
      end
      if (bus.ack1) begin
        ev_port[n_got] = 1; ev_cyc[n_got] = cyc; n_got++;
        if (!hold) bus.req1 = 1'b0;
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick();  // back to IDLE
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n_got;
    int   acks;
    vec_t v;

    rst = 1'b1;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;

    vecs[0] = '{1'b0, 1'b1, 4'h3, 4'hA, 4'h0, 4'h0};
    vecs[1] = '{1'b0, 1'b0, 4'h3, 4'h0, 4'hA, 4'h0};
    vecs[2] = '{1'b1, 1'b1, 4'h5, 4'h2, 4'hA, 4'h0};
    vecs[3] = '{1'b1, 1'b1, 4'h7, 4'hB, 4'hA, 4'h0};
    vecs[4] = '{1'b1, 1'b0, 4'h7, 4'h0, 4'hA, 4'hB};
    vecs[5] = '{1'b0, 1'b1, 4'hF, 4'h5, 4'hA, 4'hB};
    vecs[6] = '{1'b0, 1'b0, 4'hF, 4'h0, 4'h5, 4'hB};
    vecs[7] = '{1'b1, 1'b1, 4'h0, 4'hC, 4'h5, 4'hB};
    vecs[8] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h5, 4'hC};
    vecs[9] = '{1'b1, 1'b1, 4'h9, 4'hD, 4'h5, 4'hC};

    // Reset, then 5 idle cycles.
    do_reset();
    repeat (5) tick();
    check("idle ack0", int'(bus.ack0), 0);
    check("idle ack1", int'(bus.ack1), 0);
    check("idle rdata0", int'(bus.rdata0), 0);
    check("idle rdata1", int'(bus.rdata1), 0);
    check("idle ram_addr", int'(ram_addr), 0);
    check("idle ram_dataIN", int'(ram_dataIN), 0);
    check("idle busy", int'(busy), 0);
    check("idle write_en count", wen_cnt, 0);

    // Single-port transactions, including address 0 and 0xF.
    for (int i = 0; i < 10; i++) begin
      do_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Simultaneous requests: port 0 reads cell 5 (=2), port 1 writes 6.
    do_reset();
    drive_req(1'b0, 1'b0, 4'h5, 4'h0);
    drive_req(1'b1, 1'b1, 4'h5, 4'h6);
    run_both(1'b0, 2, 20, n_got);
    check("conflict ack count", n_got, 2);
    check("conflict first port", ev_port[0], 0);
    check("conflict first cycle", ev_cyc[0], 3);
    check("conflict second port", ev_port[1], 1);
    check("conflict second cycle", ev_cyc[1], 7);
    check("conflict rdata0", int'(bus.rdata0), 2);
    check("conflict rdata1", int'(bus.rdata1), 0);
    v = '{1'b0, 1'b0, 4'h5, 4'h0, 4'h6, 4'h0};
    do_txn(v, "after conflict");

    // Continuous requests on both ports for 8 acks.
    do_reset();
    drive_req(1'b0, 1'b0, 4'h3, 4'h0);
    drive_req(1'b1, 1'b0, 4'h7, 4'h0);
    run_both(1'b1, 8, 40, n_got);
    check("stream ack count", n_got, 8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("stream port %0d", k), ev_port[k], RR ? (k % 2) : 0);
      check($sformatf("stream cycle %0d", k), ev_cyc[k], 3 + 4 * k);
    end
    check("stream rdata0", int'(bus.rdata0), 'hA);
    check("stream rdata1", int'(bus.rdata1), RR ? 'hB : 0);

    // Port 1 changes addr1 during CMD: latched address 7 must be used.
    drive_req(1'b1, 1'b0, 4'h7, 4'h0);
    tick();  // CMD
    check("latch cmd addr", int'(ram_addr), 7);
    bus.addr1 = 4'h9;
    tick();  // CAPT
    check("latch capt addr", int'(ram_addr), 7);
    tick();  // ACK
    check("latch ack1", int'(bus.ack1), 1);
    check("latch rdata1", int'(bus.rdata1), 'hB);
    bus.req1 = 1'b0;
    tick();

    // Reset during CAPT of a port 0 read aborts it.
    do_reset();
    drive_req(1'b0, 1'b0, 4'h3, 4'h0);
    tick();  // CMD
    tick();  // CAPT
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req0 = 1'b0;
    check("abort ack0", int'(bus.ack0), 0);
    check("abort busy", int'(busy), 0);
    check("abort rdata0", int'(bus.rdata0), 0);
    acks = 0;
    repeat (4) begin
      tick();
      if (bus.ack0) acks++;
    end
    check("abort no late ack0", acks, 0);
    v = '{1'b0, 1'b0, 4'h3, 4'h0, 4'hA, 4'h0};
    do_txn(v, "after abort");

    // Reset during CMD of a write: the RAM still commits it.
    do_reset();
    drive_req(1'b1, 1'b1, 4'h9, 4'hE);
    tick();  // CMD
    check("cmd-reset write_en", int'(ram_write_en), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req1 = 1'b0;
    check("cmd-reset ack1", int'(bus.ack1), 0);
    check("cmd-reset busy", int'(busy), 0);
    tick();
    v = '{1'b1, 1'b0, 4'h9, 4'h0, 4'h0, 4'hE};
    do_txn(v, "after cmd reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-port access controller in front of the 16x4 data RAM of the 4-bit computer.
- Port 0 is the CPU datapath. Port 1 is the program loader/debug path.
- Serialises requests into single RAM commands and drives the RAM's write_en/addr/dataIN.
- Captures the RAM's registered dataOut and returns it to the winning requester with a one-cycle ack.

Parameters:
- ADDR_W, 4, RAM address width.
- DATA_W, 4, RAM data width.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req0  in  1  port 0 request; held high until ack0
- we0  in  1  port 0 write (1) / read (0); stable while req0 high
- addr0  in  ADDR_W  port 0 address; stable while req0 high
- wdata0  in  DATA_W  port 0 write data; stable while req0 high
- ack0  out  1  one-cycle completion pulse for port 0
- rdata0  out  DATA_W  port 0 read data, valid from ack0 onward
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1
- ram_write_en  out  1  to RAM write_en
- ram_addr  out  ADDR_W  to RAM addr
- ram_dataIN  out  DATA_W  to RAM dataIN
- ram_dataOut  in  DATA_W  from RAM dataOut (registered, one-cycle read latency)
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: state=IDLE; ack0=ack1=0; rdata0=rdata1=0; ram_write_en=0; ram_addr=0; ram_dataIN=0; busy=0; granted-port register=0.
- All outputs are registered.
- IDLE:
  - If no req, stay in IDLE.
  - Otherwise select a winner, latch its we/addr/wdata and the port index, load ram_addr/ram_dataIN/ram_write_en(=we), then go to CMD.
- CMD (1 cycle):
  - RAM command is presented. The RAM executes it at the edge ending CMD.
  - At that edge ram_write_en returns to 0. Next state is CAPT.
- CAPT (1 cycle):
  - ram_dataOut now holds the read result.
  - On a read, load rdataN of the granted port from ram_dataOut.
  - Assert ackN of the granted port for the next cycle. Next state is ACK.
- ACK (1 cycle):
  - ackN=1 and rdataN is stable. Next state is IDLE.
  - ack drops at the edge ending ACK.
- Latency: request first high in cycle T (sampled in IDLE) -> ack high in cycle T+3. The next grant can be made at the earliest at the edge ending cycle T+4.
- Throughput: one access per 4 cycles.
- rdataN holds its value until the next read completes on that port. Writes never change rdata.
- ram_addr and ram_dataIN hold their last values outside CMD. ram_write_en is high only during CMD.
- A req still high in the cycle after ack is a new transaction. Back-to-back requests are legal.
- Losing port: its request stays pending, and it gets no ack until it is served.
- Arbitration (default, fixed priority): port 0 wins whenever req0 and req1 are both high in IDLE.
- Input changes while a request is in flight (after grant) are ignored, because fields are latched at grant.
- Reset mid-operation:
  - Aborts the transaction. No ack is issued, and the state returns to IDLE.
  - If rst is high in the CMD cycle of a write, the RAM (unreset) still commits that write.
- Address wrap: not applicable; every ADDR_W value is a valid cell.

Optional Feature:
- Macro: RAM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit last-grant pointer (reset 1) gives priority to the port not granted last.
  - With continuous req0 and req1, grants alternate 0,1,0,1...
  - The pointer updates only on grant.
- Undefined: fixed priority, with port 0 always winning a conflict.
  - No pointer register exists.

Decomposition:
- Package ram_arb_pkg holds:
  - ADDR_W/DATA_W default constants.
  - State enum typedef: IDLE, CMD, CAPT, ACK.
  - Request struct typedef: we, addr, wdata.
- Sub-module ram_arb_pick: combinational winner select from req0, req1 and (under RAM_ARB_RR_EN) the last-grant pointer. It outputs a grant-valid bit and the port index.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, busy=0, ram_write_en never high.
- Port 0 write addr=4'h3 wdata=4'hA, then port 0 read addr=4'h3 -> write ack0 at T+3; read ack0 at T+3 with rdata0=4'hA; rdata1 stays 0.
- req0 and req1 rise together (port 0 read addr 5, port 1 write addr 5 data 4'h6, cell 5 preloaded with 4'h2):
  - Fixed priority: ack0 first with rdata0=4'h2, then ack1 four cycles later.
  - RR_EN from reset: same order, next conflict grants port 1 first.
- Both ports hold req continuously for 8 transactions -> with RAM_ARB_RR_EN, acks alternate 0,1,0,1... Without it, port 0 starves port 1 (no ack1).
- Port 1 changes addr1 from 4'h7 to 4'h9 during CMD -> RAM sees addr 4'h7 only, and rdata1 = contents of cell 7.
- Assert rst during CAPT of a port 0 read -> no ack0, rdata0 unchanged, state IDLE, busy=0 next cycle. A later read still completes normally.
